wja_axil_bus_bridge: RTL and testbench

WJA_AXIL_BUS_BRIDGE -- requirements
Module: wja_axil_bus_bridge

---
 rtl/wja_bus_pkg.sv | 22 ++
 rtl/wja_bus_timeout.sv | 33 +++
 rtl/wja_axil_bus_bridge.sv | 145 ++++++++++++++
 tb/tb_wja_axil_bus_bridge.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wja_bus_pkg.sv
// Shared types and constants for the AXI-Lite to local-bus bridge.
// Holds the FSM state encoding, AXI response codes and the captured response struct.
package wja_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_BUS,
        RD_BUS,
        WR_RESP,
        RD_RESP
    } bus_state_e;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] rdata;
    } bus_rsp_t;

endpackage

// File: rtl/wja_bus_timeout.sv
// Request watchdog: start arms and zeroes the counter, clear disarms it, and
// expired is raised on the TIMEOUT-th armed cycle.
module wja_bus_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear,
    output logic expired
);

    logic        armed;
    logic [15:0] cnt;

    assign expired = armed && (cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
            cnt   <= '0;
        end else if (clear) begin
            armed <= 1'b0;
            cnt   <= '0;
        end else if (start) begin
            armed <= 1'b1;
            cnt   <= '0;
        end else if (armed && !expired) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/wja_axil_bus_bridge.sv
// AXI4-Lite slave bridging to a simple req/ack local bus, one transaction in flight.
// Simultaneous read/write requests alternate through a priority bit.
module wja_axil_bus_bridge
    import wja_bus_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic [31:0]       s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [31:0]       s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic              bus_wr,
    output logic              bus_rd,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack
);

    bus_state_e        state, state_n;
    bus_rsp_t          rsp_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              prio_wr;
    logic              armed;
    logic              tmo_start, tmo_clear, tmo_expired;
    logic              wr_pend, rd_pend, grant_wr, grant_rd, strb_ok;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

    // armed keeps the readies low while reset is asserted even if valids are high
    assign wr_pend  = s_axi_awvalid && s_axi_wvalid;
    assign rd_pend  = s_axi_arvalid;
    assign grant_wr = armed && wr_pend && (prio_wr || !rd_pend);
    assign grant_rd = armed && rd_pend && !(wr_pend && prio_wr);
    assign strb_ok  = (s_axi_wstrb == 4'hF);

    wja_bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .start   (tmo_start),
        .clear   (tmo_clear),
        .expired (tmo_expired)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n       = state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_arready = 1'b0;
        tmo_start     = 1'b0;
        tmo_clear     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_wr) begin
                    s_axi_awready = 1'b1;
                    s_axi_wready  = 1'b1;
                    if (strb_ok) begin
                        state_n   = WR_BUS;
                        tmo_start = 1'b1;
                    end else begin
                        state_n = WR_RESP;
                    end
                end else if (grant_rd) begin
                    s_axi_arready = 1'b1;
                    state_n       = RD_BUS;
                    tmo_start     = 1'b1;
                end
            end
            WR_BUS: begin
                if (bus_ack || tmo_expired) begin
                    tmo_clear = 1'b1;
                    state_n   = WR_RESP;
                end
            end
            RD_BUS: begin
                if (bus_ack || tmo_expired) begin
                    tmo_clear = 1'b1;
                    state_n   = RD_RESP;
                end
            end
            WR_RESP: if (s_axi_bready) state_n = IDLE;
            RD_RESP: if (s_axi_rready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // ack on the final watchdog cycle still counts as a successful completion
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rsp_q   <= '0;
            prio_wr <= 1'b1;
            armed   <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (s_axi_awready) begin
                addr_q  <= s_axi_awaddr[ADDR_W+1:2];
                wdata_q <= s_axi_wdata;
                rsp_q   <= '{resp: (strb_ok ? RESP_OKAY : RESP_SLVERR), rdata: 32'h0};
                prio_wr <= 1'b0;
            end else if (s_axi_arready) begin
                addr_q  <= s_axi_araddr[ADDR_W+1:2];
                prio_wr <= 1'b1;
            end else if (bus_wr || bus_rd) begin
                if (bus_ack)          rsp_q <= '{resp: RESP_OKAY, rdata: bus_rdata};
                else if (tmo_expired) rsp_q <= '{resp: RESP_SLVERR, rdata: ERR_RDATA};
            end
        end
    end

    assign bus_wr       = (state == WR_BUS);
    assign bus_rd       = (state == RD_BUS);
    assign bus_addr     = addr_q;
    assign bus_wdata    = wdata_q;
    assign s_axi_bvalid = (state == WR_RESP);
    assign s_axi_bresp  = s_axi_bvalid ? rsp_q.resp : 2'b00;
    assign s_axi_rvalid = (state == RD_RESP);
    assign s_axi_rresp  = s_axi_rvalid ? rsp_q.resp : 2'b00;
    assign s_axi_rdata  = s_axi_rvalid ? rsp_q.rdata : 32'h0;

endmodule

// File: tb/tb_wja_axil_bus_bridge.sv
// Scoreboard bench for wja_axil_bus_bridge: driver plans expected bus and AXI
// responses from the transfer rules, monitors pop and compare independently.
module tb_wja_axil_bus_bridge;

    localparam int ADDR_W = 16;
    localparam int TO     = 8;

    logic              ACLK = 1'b0;
    logic              ARESETN = 1'b0;
    logic [31:0]       s_axi_awaddr = '0, s_axi_wdata = '0, s_axi_araddr = '0;
    logic [3:0]        s_axi_wstrb = '0;
    logic              s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_arvalid = 1'b0;
    logic              s_axi_bready = 1'b1, s_axi_rready = 1'b1;
    logic              s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid;
    logic [1:0]        s_axi_bresp, s_axi_rresp;
    logic [31:0]       s_axi_rdata;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic              bus_wr, bus_rd;
    logic [31:0]       bus_rdata = '0;
    logic              bus_ack = 1'b0;

    always #5 ACLK = ~ACLK;

    wja_axil_bus_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wr(bus_wr), .bus_rd(bus_rd),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        bit          is_wr;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        bit                is_wr;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        int                ack_at;
        logic [31:0]       rdata;
    } bus_t;

    exp_t exp_q[$];
    bus_t bus_q[$];
    bit   model_prio_wr = 1'b1;
    int   rdy_mode = 1;
    bit   abort_flag = 1'b0;

    // ack_at is the request cycle (1-based) the responder acks on; 0 means never
    function automatic bit bus_ok(input int ack_at);
        return (ack_at >= 1) && (ack_at <= TO);
    endfunction

    function automatic int exp_len(input int ack_at);
        return bus_ok(ack_at) ? ack_at : TO;
    endfunction

    task automatic plan_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int ack_at);
        exp_t e;
        bus_t b;
        e.is_wr = 1'b1;
        e.rdata = '0;
        if (s != 4'hF) begin
            e.resp = 2'b10;
        end else begin
            e.resp   = bus_ok(ack_at) ? 2'b00 : 2'b10;
            b.is_wr  = 1'b1;
            b.addr   = ADDR_W'(a >> 2);
            b.wdata  = d;
            b.ack_at = ack_at;
            b.rdata  = $urandom;
            bus_q.push_back(b);
        end
        exp_q.push_back(e);
    endtask

    task automatic plan_rd(input logic [31:0] a, input logic [31:0] rd, input int ack_at);
        exp_t e;
        bus_t b;
        b.is_wr  = 1'b0;
        b.addr   = ADDR_W'(a >> 2);
        b.wdata  = '0;
        b.ack_at = ack_at;
        b.rdata  = rd;
        bus_q.push_back(b);
        e.is_wr = 1'b0;
        e.resp  = bus_ok(ack_at) ? 2'b00 : 2'b10;
        e.rdata = bus_ok(ack_at) ? rd : 32'hDEAD_BEEF;
        exp_q.push_back(e);
    endtask

    task automatic issue(input bit dw, input bit dr,
                         input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws, input int wack,
                         input logic [31:0] ra, input logic [31:0] rdat, input int rack);
        bit wacc, racc;
        int n;
        if (dw && dr) begin
            if (model_prio_wr) begin plan_wr(wa, wd, ws, wack); plan_rd(ra, rdat, rack); end
            else begin plan_rd(ra, rdat, rack); plan_wr(wa, wd, ws, wack); end
        end else if (dw) begin
            plan_wr(wa, wd, ws, wack);
            model_prio_wr = 1'b0;
        end else begin
            plan_rd(ra, rdat, rack);
            model_prio_wr = 1'b1;
        end
        @(posedge ACLK); #2;
        if (dw) begin
            s_axi_awaddr = wa; s_axi_wdata = wd; s_axi_wstrb = ws;
            s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        end
        if (dr) begin
            s_axi_araddr = ra; s_axi_arvalid = 1'b1;
        end
        wacc = !dw;
        racc = !dr;
        n = 0;
        while (!(wacc && racc) && n < 200) begin
            @(negedge ACLK);
            n++;
            if (s_axi_awvalid && s_axi_awready) wacc = 1'b1;
            if (s_axi_arvalid && s_axi_arready) racc = 1'b1;
            @(posedge ACLK); #2;
            if (wacc) begin s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; end
            if (racc) s_axi_arvalid = 1'b0;
        end
        if (!(wacc && racc)) chk("accept_timeout", {wacc, racc}, 2'b11);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge ACLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
            bus_q.delete();
        end
    endtask

    // ready driver
    always @(posedge ACLK) begin
        #2;
        case (rdy_mode)
            0: begin s_axi_bready = 1'($urandom_range(0, 1)); s_axi_rready = 1'($urandom_range(0, 1)); end
            2: begin s_axi_bready = 1'b0; s_axi_rready = 1'b0; end
            default: begin s_axi_bready = 1'b1; s_axi_rready = 1'b1; end
        endcase
    end

    // AXI response monitor
    exp_t        mon_e;
    bit          prev_b_stall = 1'b0, prev_r_stall = 1'b0;
    logic [1:0]  prev_bresp, prev_rresp;
    logic [31:0] prev_rdata;

    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (prev_b_stall) begin
                chk("bvalid_hold", s_axi_bvalid, 1);
                chk("bresp_hold", s_axi_bresp, prev_bresp);
            end
            if (prev_r_stall) begin
                chk("rvalid_hold", s_axi_rvalid, 1);
                chk("rresp_hold", s_axi_rresp, prev_rresp);
                chk("rdata_hold", s_axi_rdata, prev_rdata);
            end
            if (s_axi_awready || s_axi_wready)
                chk("aw_w_ready_pair", {s_axi_awready, s_axi_wready, s_axi_awvalid, s_axi_wvalid}, 4'hF);
            if (s_axi_bvalid && s_axi_bready) begin
                if (exp_q.size() == 0) chk("unexpected_b", s_axi_bvalid, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("order_expect_wr", mon_e.is_wr, 1);
                    chk("bresp", s_axi_bresp, mon_e.resp);
                end
            end
            if (s_axi_rvalid && s_axi_rready) begin
                if (exp_q.size() == 0) chk("unexpected_r", s_axi_rvalid, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("order_expect_rd", mon_e.is_wr, 0);
                    chk("rresp", s_axi_rresp, mon_e.resp);
                    chk("rdata", s_axi_rdata, mon_e.rdata);
                end
            end
            prev_b_stall = s_axi_bvalid && !s_axi_bready;
            prev_r_stall = s_axi_rvalid && !s_axi_rready;
            prev_bresp   = s_axi_bresp;
            prev_rresp   = s_axi_rresp;
            prev_rdata   = s_axi_rdata;
        end else begin
            prev_b_stall = 1'b0;
            prev_r_stall = 1'b0;
        end
    end

    // local-bus responder: checks request fields and length, acks on the planned cycle
    bus_t cur;
    int   cyc = 0;

    always @(negedge ACLK) begin
        if (ARESETN && (bus_wr || bus_rd)) begin
            if (cyc == 0) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_bus_req", {bus_wr, bus_rd}, 2'b00);
                    cur.is_wr = bus_wr; cur.addr = bus_addr; cur.wdata = bus_wdata;
                    cur.ack_at = 0; cur.rdata = '0;
                end else begin
                    cur = bus_q.pop_front();
                end
                chk("bus_dir", {bus_wr, bus_rd}, {cur.is_wr, !cur.is_wr});
            end
            cyc++;
            chk("bus_addr", bus_addr, cur.addr);
            if (cur.is_wr) chk("bus_wdata", bus_wdata, cur.wdata);
            bus_ack   = (cyc == cur.ack_at);
            bus_rdata = bus_ack ? cur.rdata : $urandom;
        end else begin
            if (cyc != 0 && !abort_flag) chk("bus_req_len", cyc, exp_len(cur.ack_at));
            cyc       = 0;
            bus_ack   = ($urandom_range(0, 3) == 0);
            bus_rdata = $urandom;
        end
    end

    initial begin
        int n;
        int kind;
        // reset state with all valids high
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1; s_axi_wstrb = 4'hF;
        #12;
        chk("reset_axi_out", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_bresp,
                              s_axi_rvalid, s_axi_rresp, s_axi_rdata}, 0);
        chk("reset_bus_out", {bus_wr, bus_rd, bus_addr, bus_wdata}, 0);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        @(posedge ACLK); #2;
        ARESETN = 1'b1;
        repeat (2) @(posedge ACLK);

        issue(1, 0, 32'h8, 32'h3, 4'hF, 3, 0, 0, 0);
        drain();
        issue(0, 1, 0, 0, 0, 0, 32'hC, 32'h1234_5678, 2);
        drain();
        issue(0, 1, 0, 0, 0, 0, 32'h40, 32'h5555_AAAA, 0);
        drain();

        // partial strobe, response stalled for 5 cycles
        rdy_mode = 2;
        issue(1, 0, 32'h10, 32'hCAFE_F00D, 4'h3, 1, 0, 0, 0);
        n = 0;
        while (!s_axi_bvalid && n < 50) begin @(negedge ACLK); n++; end
        repeat (5) begin
            @(negedge ACLK);
            chk("bvalid_stalled", {s_axi_bvalid, s_axi_bresp}, 3'b110);
        end
        rdy_mode = 1;
        drain();

        // reset in the middle of a read bus cycle
        issue(0, 1, 0, 0, 0, 0, 32'h20, 32'h0, 0);
        n = 0;
        while (!bus_rd && n < 50) begin @(negedge ACLK); n++; end
        chk("rd_started", bus_rd, 1);
        repeat (3) @(posedge ACLK);
        #2;
        abort_flag = 1'b1;
        ARESETN = 1'b0;
        #1;
        chk("rst_bus_rd_now", {bus_rd, bus_wr, s_axi_rvalid}, 0);
        exp_q.delete();
        bus_q.delete();
        model_prio_wr = 1'b1;
        @(posedge ACLK); #2;
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
        abort_flag = 1'b0;
        issue(0, 1, 0, 0, 0, 0, 32'h24, 32'h0BAD_CAFE, 4);
        drain();

        // simultaneous write and read, twice
        repeat (2) begin
            issue(1, 1, 32'h30, $urandom, 4'hF, 2, 32'h34, $urandom, 3);
            drain();
        end

        repeat (40) begin
            rdy_mode = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 2));
            issue(kind != 1, kind != 0,
                  $urandom, $urandom,
                  ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF,
                  int'($urandom_range(0, 10)),
                  $urandom, $urandom, int'($urandom_range(0, 10)));
            drain();
        end
        rdy_mode = 1;
        repeat (3) @(posedge ACLK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
